// File: rtl/ofdm_subcarrier_sched.sv
// Subcarrier scheduler: builds 64-bin IFFT-ordered OFDM symbols from mapped data points.
// Optional `SUBC_PILOT_POLARITY_EN enables LFSR-driven pilot polarity (otherwise p = +1).
module ofdm_subcarrier_sched (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic [31:0] DAT_I,
    input  logic        CYC_I,
    input  logic        STB_I,
    input  logic        WE_I,
    output logic        ACK_O,
    output logic [31:0] DAT_O,
    output logic        CYC_O,
    output logic        STB_O,
    output logic        WE_O,
    output logic        SOS_O,
    input  logic        ACK_I
);
    localparam logic [15:0] PILOT_P = 16'h7FFF;
    localparam logic [15:0] PILOT_N = 16'h8001;

    typedef enum logic [1:0] {IDLE, RUN, PAD, DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  bin_q, bin_d;
    logic        last_q, last_d;
    logic [31:0] dat_q, dat_d;
    logic        stb_q, stb_d;
    logic        sos_q, sos_d;
    logic        cyc_q, cyc_d;
    logic [7:0]  sym_cnt_q, sym_cnt_d;

    logic        out_halt, is_null, is_pilot, is_data, pilot_neg;
    logic        emit, end_evt, busy, pol;
    logic [31:0] bin_val;

    assign out_halt = stb_q & ~ACK_I;
    assign busy     = (state_q == RUN) || (state_q == PAD);
    assign is_null  = (bin_q == 6'd0) || ((bin_q >= 6'd27) && (bin_q <= 6'd37));
    assign is_pilot = (bin_q == 6'd7) || (bin_q == 6'd21) || (bin_q == 6'd43) || (bin_q == 6'd57);
    assign is_data  = ~is_null & ~is_pilot;
    assign pilot_neg = (bin_q == 6'd57) ^ pol;

    assign ACK_O = (state_q == RUN) & is_data & CYC_I & STB_I & WE_I & ~out_halt;

    // last_q marks bin 63 sitting in the output register; the symbol ends when it is taken
    assign end_evt = busy & last_q & ~out_halt;
    assign emit    = busy & ~out_halt
                   & (~last_q | ((state_q == RUN) & CYC_I))
                   & (~is_data | ACK_O | (state_q == PAD));

    always_comb begin
        bin_val = 32'h0;
        if (is_pilot) begin
            bin_val = {16'h0, (pilot_neg ? PILOT_N : PILOT_P)};
        end else if (is_data && (state_q == RUN)) begin
            bin_val = DAT_I;
        end
    end

`ifdef SUBC_PILOT_POLARITY_EN
    logic [6:0] lfsr_q, lfsr_d;

    assign pol = lfsr_q[6] ^ lfsr_q[3];

    always_comb begin
        lfsr_d = lfsr_q;
        if (end_evt) begin
            lfsr_d = {lfsr_q[5:0], pol};
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            lfsr_q <= 7'h7F;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign pol = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        last_d    = last_q;
        dat_d     = dat_q;
        stb_d     = stb_q;
        sos_d     = sos_q;
        sym_cnt_d = sym_cnt_q;
        cyc_d     = busy;

        if (!out_halt) begin
            stb_d = 1'b0;
            sos_d = 1'b0;
        end

        if (end_evt) begin
            last_d    = 1'b0;
            sym_cnt_d = sym_cnt_q + 8'd1;
        end

        if (emit) begin
            dat_d = bin_val;
            stb_d = 1'b1;
            sos_d = (bin_q == 6'd0);
            if (bin_q == 6'd63) begin
                last_d = 1'b1;
                bin_d  = 6'd0;
            end else begin
                bin_d = bin_q + 6'd1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (CYC_I) begin
                    state_d = RUN;
                    bin_d   = 6'd0;
                    last_d  = 1'b0;
                end
            end
            RUN: begin
                if (end_evt && !CYC_I) begin
                    state_d = DONE;
                end else if (!last_q && is_data && !CYC_I) begin
                    state_d = PAD;
                end
            end
            PAD: begin
                if (end_evt) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q   <= IDLE;
            bin_q     <= 6'd0;
            last_q    <= 1'b0;
            dat_q     <= 32'h0;
            stb_q     <= 1'b0;
            sos_q     <= 1'b0;
            cyc_q     <= 1'b0;
            sym_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            last_q    <= last_d;
            dat_q     <= dat_d;
            stb_q     <= stb_d;
            sos_q     <= sos_d;
            cyc_q     <= cyc_d;
            sym_cnt_q <= sym_cnt_d;
        end
    end

    assign DAT_O = dat_q;
    assign STB_O = stb_q;
    assign WE_O  = stb_q;
    assign SOS_O = sos_q;
    assign CYC_O = cyc_q;
endmodule

// File: tb/tb_ofdm_subcarrier_sched.sv
// Scoreboard bench for ofdm_subcarrier_sched: expected bin words are queued as stimulus is built
// and compared as downstream accepts them.
module tb_ofdm_subcarrier_sched;
    logic        CLK_I = 1'b0;
    logic        RST_I;
    logic [31:0] DAT_I;
    logic        CYC_I, STB_I, WE_I;
    logic        ACK_O;
    logic [31:0] DAT_O;
    logic        CYC_O, STB_O, WE_O, SOS_O;
    logic        ACK_I;

    ofdm_subcarrier_sched dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .DAT_I(DAT_I), .CYC_I(CYC_I), .STB_I(STB_I),
        .WE_I(WE_I), .ACK_O(ACK_O), .DAT_O(DAT_O), .CYC_O(CYC_O), .STB_O(STB_O),
        .WE_O(WE_O), .SOS_O(SOS_O), .ACK_I(ACK_I)
    );

    always #5 CLK_I = ~CLK_I;

    // Pilot polarity for symbols 0..7 after reset (1 = negative)
`ifdef SUBC_PILOT_POLARITY_EN
    logic [7:0] polBits = 8'b0111_0000;
`else
    logic [7:0] polBits = 8'b0000_0000;
`endif

    logic [32:0] expQ[$];
    logic [31:0] inQ[$];
    int checks = 0;
    int errors = 0;
    int expSym = 0;
    int popCount = 0;
    int cycNo = 0;
    int ackMode = 0;
    int gapMode = 0;
    int gapCnt = 0;
    logic pend = 1'b0;
    logic prevHalt = 1'b0;
    logic [31:0] prevDat = 32'h0;
    logic sawStall = 1'b0;
    logic timedOut = 1'b0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Builds input words and the expected output stream for nSyms symbols
    task automatic applyStimulus(input int nWords, input int nSyms, input int ack, input int gap);
        logic [31:0] words[$];
        int widx;
        logic neg;
        logic [31:0] val;
        for (int i = 0; i < nWords; i++) begin
            words.push_back($urandom | 32'h1);
            inQ.push_back(words[i]);
        end
        widx = 0;
        for (int s = 0; s < nSyms; s++) begin
            for (int b = 0; b < 64; b++) begin
                if (b == 0 || (b >= 27 && b <= 37)) begin
                    val = 32'h0;
                end else if (b == 7 || b == 21 || b == 43 || b == 57) begin
                    neg = (b == 57) ^ polBits[expSym];
                    val = neg ? 32'h0000_8001 : 32'h0000_7FFF;
                end else if (widx < nWords) begin
                    val = words[widx];
                    widx++;
                end else begin
                    val = 32'h0;
                end
                expQ.push_back({(b == 0), val});
            end
            expSym++;
        end
        ackMode = ack;
        gapMode = gap;
        gapCnt = 0;
        pend = 1'b0;
        prevHalt = 1'b0;
        sawStall = 1'b0;
    endtask

    task automatic stepCycle();
        logic accept, ackSeen;
        logic [32:0] e;
        @(negedge CLK_I);
        cycNo++;
        ACK_I = (ackMode == 1) ? cycNo[0] : 1'b1;
        if (inQ.size() > 0) begin
            if (!pend) begin
                if (gapCnt == 0) pend = 1'b1;
                else gapCnt--;
            end
            CYC_I = 1'b1;
            STB_I = pend;
            DAT_I = inQ[0];
        end else begin
            CYC_I = 1'b0;
            STB_I = 1'b0;
            DAT_I = 32'h0;
        end
        WE_I = STB_I;
        #1;
        if (prevHalt) begin
            checkOutput("hold stb", {63'h0, STB_O}, 64'h1);
            checkOutput("hold dat", {32'h0, DAT_O}, {32'h0, prevDat});
        end
        if (STB_O && !ACK_I) checkOutput("ack_o in halt", {63'h0, ACK_O}, 64'h0);
        if (gapMode != 0 && CYC_O && !STB_O) sawStall = 1'b1;
        prevHalt = STB_O & ~ACK_I;
        prevDat  = DAT_O;
        accept   = STB_O & ACK_I;
        ackSeen  = ACK_O;
        if (accept) begin
            if (expQ.size() == 0) begin
                checkOutput("extra word", {31'h0, SOS_O, DAT_O}, 64'h0);
            end else begin
                e = expQ.pop_front();
                checkOutput($sformatf("bin %0d", popCount % 64), {31'h0, SOS_O, DAT_O}, {31'h0, e});
            end
            popCount++;
        end
        @(posedge CLK_I);
        if (ackSeen && inQ.size() > 0) begin
            void'(inQ.pop_front());
            pend = 1'b0;
            gapCnt = (gapMode != 0) ? 3 : 0;
        end
    endtask

    task automatic runStream(input int budget, input int stopPops);
        int n;
        n = 0;
        timedOut = 1'b0;
        popCount = 0;
        while (!((expQ.size() == 0 && inQ.size() == 0 && CYC_O == 1'b0 && n > 2) || popCount >= stopPops)) begin
            if (n >= budget) begin
                timedOut = 1'b1;
                break;
            end
            stepCycle();
            n++;
        end
        checkOutput("timeout", {63'h0, timedOut}, 64'h0);
    endtask

    task automatic applyReset();
        @(negedge CLK_I);
        RST_I = 1'b1; CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; DAT_I = 32'h0; ACK_I = 1'b1;
        repeat (2) @(posedge CLK_I);
        @(negedge CLK_I);
        RST_I = 1'b0;
        expQ.delete();
        inQ.delete();
        expSym = 0;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, " dat_o"}, {32'h0, DAT_O}, 64'h0);
        checkOutput({tag, " stb_o"}, {63'h0, STB_O}, 64'h0);
        checkOutput({tag, " cyc_o"}, {63'h0, CYC_O}, 64'h0);
        checkOutput({tag, " sos_o"}, {63'h0, SOS_O}, 64'h0);
        checkOutput({tag, " ack_o"}, {63'h0, ACK_O}, 64'h0);
    endtask

    initial begin
        RST_I = 1'b1; CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; DAT_I = 32'h0; ACK_I = 1'b0;

        applyReset();
        #1 checkIdleOutputs("reset");

        $display("[TB] single symbol, continuous stream");
        applyStimulus(48, 1, 0, 0);
        runStream(400, 1 << 30);
        checkOutput("t1 words out", popCount, 64);
        checkOutput("t1 scoreboard empty", expQ.size(), 0);

        $display("[TB] five symbols back-to-back");
        applyReset();
        applyStimulus(5 * 48, 5, 0, 0);
        runStream(1000, 1 << 30);
        checkOutput("t2 words out", popCount, 5 * 64);
        checkOutput("t2 scoreboard empty", expQ.size(), 0);

        $display("[TB] downstream ACK_I toggling");
        applyReset();
        applyStimulus(48, 1, 1, 0);
        runStream(800, 1 << 30);
        checkOutput("t3 words out", popCount, 64);

        $display("[TB] upstream drops after 10 words");
        applyReset();
        applyStimulus(10, 1, 0, 0);
        runStream(400, 1 << 30);
        checkOutput("t4 words out", popCount, 64);
        checkOutput("t4 cyc_o low", {63'h0, CYC_O}, 64'h0);

        $display("[TB] upstream strobe gaps");
        applyReset();
        applyStimulus(48, 1, 0, 1);
        runStream(1000, 1 << 30);
        checkOutput("t5 words out", popCount, 64);
        checkOutput("t5 stall seen", {63'h0, sawStall}, 64'h1);

        $display("[TB] reset at bin 30 of symbol 4");
        applyReset();
        applyStimulus(5 * 48, 5, 0, 0);
        runStream(1000, 4 * 64 + 30);
        checkOutput("t6 reached bin 30", popCount, 4 * 64 + 30);
        @(negedge CLK_I);
        RST_I = 1'b1; CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
        @(posedge CLK_I);
        #1 checkIdleOutputs("abort");
        @(negedge CLK_I);
        RST_I = 1'b0;
        expQ.delete();
        inQ.delete();
        expSym = 0;
        applyStimulus(48, 1, 0, 0);
        runStream(400, 1 << 30);
        checkOutput("t6 restart words", popCount, 64);
        checkOutput("t6 scoreboard empty", expQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
